store_drain_queue: RTL and testbench



---
 rtl/store_drain_queue.sv | 148 ++++++++++++++
 tb/tb_store_drain_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_queue.sv
// Store drain queue: captures retired stores and drains them to memory.
// Optional write combining under STORE_DRAIN_WRITE_COMBINE_EN.
module store_drain_queue #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2,
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                wr_en_i,
  input  logic [ADDR_LEN-1:0] wr_addr_i,
  input  logic [DATA_LEN-1:0] wr_data_i,
  input  logic [ADDR_LEN-1:0] ld_addr_i,
  output logic                ld_hit_o,
  output logic [DATA_LEN-1:0] ld_data_o,
  output logic                mem_req_o,
  output logic [ADDR_LEN-1:0] mem_addr_o,
  output logic [DATA_LEN-1:0] mem_data_o,
  input  logic                mem_ack_i,
  output logic                full_o,
  output logic                drained_o,
  output logic                overflow_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [DEPTH_BITS:0] LP_FULL =
    DEPTH[DEPTH_BITS:0];
  localparam logic [DEPTH_BITS-1:0] LP_ONE =
    {{(DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS:0] LP_ZERO = '0;

  state_e r_state;
  state_e w_state_nxt;

  logic [ADDR_LEN-1:0]   r_addr [DEPTH];
  logic [DATA_LEN-1:0]   r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH_BITS-1:0] r_head;
  logic [DEPTH_BITS-1:0] r_tail;
  logic [DEPTH_BITS:0]   r_count;
  logic [DEPTH_BITS:0]   w_count_nxt;
  logic                  r_ovf;

  logic w_deq;
  logic w_room;
  logic w_comb;
  logic w_enq;
  logic w_drop;

  assign w_deq  = (r_state == SEND) && mem_ack_i;
  assign w_room = (r_count < LP_FULL) || w_deq;

`ifdef STORE_DRAIN_WRITE_COMBINE_EN
  logic [DEPTH_BITS-1:0] w_yidx;
  assign w_yidx = r_tail - LP_ONE;
  // An in-flight head must not change under the request.
  assign w_comb = wr_en_i
               && r_valid[w_yidx]
               && (r_addr[w_yidx] == wr_addr_i)
               && !((w_yidx == r_head)
                    && (r_state == SEND));
`else
  assign w_comb = 1'b0;
`endif

  assign w_enq  = wr_en_i && !w_comb && w_room;
  assign w_drop = wr_en_i && !w_comb && !w_room;

  assign w_count_nxt = r_count
                     + {{DEPTH_BITS{1'b0}}, w_enq}
                     - {{DEPTH_BITS{1'b0}}, w_deq};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_count != LP_ZERO) w_state_nxt = SEND;
      end
      SEND: begin
        if (w_deq && (w_count_nxt == LP_ZERO))
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_drop) r_ovf <= 1'b1;
      if (w_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + LP_ONE;
      end
      // Enqueue after pop so a full-queue refill keeps its valid bit.
      if (w_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= wr_addr_i;
        r_data[r_tail]  <= wr_data_i;
        r_tail          <= r_tail + LP_ONE;
      end
`ifdef STORE_DRAIN_WRITE_COMBINE_EN
      if (w_comb) r_data[w_yidx] <= wr_data_i;
`endif
    end
  end

  always_comb begin
    logic [DEPTH_BITS-1:0] idx;
    idx       = '0;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    // Walk oldest to youngest; the last match wins.
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + i[DEPTH_BITS-1:0];
      if (r_valid[idx] && (r_addr[idx] == ld_addr_i)) begin
        ld_hit_o  = 1'b1;
        ld_data_o = r_data[idx];
      end
    end
  end

  assign mem_req_o  = (r_state == SEND);
  assign mem_addr_o = mem_req_o ? r_addr[r_head] : '0;
  assign mem_data_o = mem_req_o ? r_data[r_head] : '0;
  assign full_o     = (r_count == LP_FULL);
  assign drained_o  = (r_count == LP_ZERO)
                   && (r_state == IDLE);
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_store_drain_queue.sv
// Scoreboard bench for store_drain_queue.
// Define STORE_DRAIN_WRITE_COMBINE_EN to cover combining.
module tb_store_drain_queue;

  logic        clk_i;
  logic        reset_i;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;
  logic        full_o;
  logic        drained_o;
  logic        overflow_o;

  logic [31:0] sb_a[$];
  logic [31:0] sb_d[$];
  int n_chk;
  int n_pass;

  store_drain_queue #(
    .DEPTH(4), .DEPTH_BITS(2),
    .ADDR_LEN(32), .DATA_LEN(32)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .wr_en_i(wr_en_i),
    .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i),
    .ld_addr_i(ld_addr_i),
    .ld_hit_o(ld_hit_o),
    .ld_data_o(ld_data_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i),
    .full_o(full_o),
    .drained_o(drained_o),
    .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d,
                       input bit acc);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    if (acc) begin
      sb_a.push_back(a);
      sb_d.push_back(d);
    end
    tick(1);
    wr_en_i = 1'b0;
  endtask

  task automatic wait_drained(input int max);
    int k;
    k = 0;
    while (!drained_o && k < max) begin
      tick(1);
      k++;
    end
    check("drained", drained_o, 1);
    check("sb_empty", sb_a.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (reset_i && mem_req_o && mem_ack_i) begin
      check("sb_pending", sb_a.size() != 0, 1);
      if (sb_a.size() != 0) begin
        check("mem_addr", mem_addr_o, sb_a.pop_front());
        check("mem_data", mem_data_o, sb_d.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    reset_i = 1'b0;
    wr_en_i = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    ld_addr_i = '0;
    mem_ack_i = 1'b0;
    #1;
    check("rst_req", mem_req_o, 0);
    check("rst_drained", drained_o, 1);
    check("rst_full", full_o, 0);
    check("rst_hit", ld_hit_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_addr", mem_addr_o, 0);
    tick(1);
    reset_i = 1'b1;
    tick(1);

    // single store latency
    mem_ack_i = 1'b1;
    store(32'h100, 32'hDEAD, 1);
    check("lat_early", mem_req_o, 0);
    tick(1);
    check("lat_req", mem_req_o, 1);
    check("lat_addr", mem_addr_o, 32'h100);
    tick(1);
    check("single_idle", mem_req_o, 0);
    check("single_drained", drained_o, 1);
    check("idle_addr", mem_addr_o, 0);

    // backpressure
    mem_ack_i = 1'b0;
    store(32'h10, 32'd1, 1);
    store(32'h14, 32'd2, 1);
    store(32'h18, 32'd3, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_req", mem_req_o, 1);
      check("bp_addr", mem_addr_o, 32'h10);
      check("bp_data", mem_data_o, 32'd1);
      tick(1);
    end
    mem_ack_i = 1'b1;
    wait_drained(20);

    // overflow
    mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++)
      store(32'h200 + 4 * i, 32'h50 + i, 1);
    check("ovf_full", full_o, 1);
    check("ovf_pre", overflow_o, 0);
    store(32'h210, 32'h99, 0);
    check("ovf_set", overflow_o, 1);
    check("ovf_full2", full_o, 1);
    mem_ack_i = 1'b1;
    wait_drained(20);
    check("ovf_sticky", overflow_o, 1);

    reset_i = 1'b0;
    #2;
    check("ovf_clr", overflow_o, 0);
    reset_i = 1'b1;
    tick(1);

    // full queue with simultaneous pop
    mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++)
      store(32'h300 + 4 * i, 32'h60 + i, 1);
    check("fa_full", full_o, 1);
    mem_ack_i = 1'b1;
    store(32'h310, 32'h77, 1);
    check("fa_ovf", overflow_o, 0);
    check("fa_full2", full_o, 1);
    wait_drained(20);

    // forwarding
    mem_ack_i = 1'b0;
    ld_addr_i = 32'h20;
    store(32'h20, 32'd5, 1);
    store(32'h28, 32'd9, 1);
    wr_en_i   = 1'b1;
    wr_addr_i = 32'h20;
    wr_data_i = 32'd7;
    sb_a.push_back(32'h20);
    sb_d.push_back(32'd7);
    #1;
    check("fwd_same_cyc", ld_data_o, 32'd5);
    tick(1);
    wr_en_i = 1'b0;
    #1;
    check("fwd_hit", ld_hit_o, 1);
    check("fwd_data", ld_data_o, 32'd7);
    ld_addr_i = 32'h24;
    #1;
    check("fwd_miss", ld_hit_o, 0);
    check("fwd_miss_d", ld_data_o, 0);
    ld_addr_i = 32'h28;
    #1;
    check("fwd_mid", ld_data_o, 32'd9);
    mem_ack_i = 1'b1;
    wait_drained(20);
    ld_addr_i = 32'h20;
    #1;
    check("fwd_gone", ld_hit_o, 0);

    // async reset mid-request
    tick(1);
    mem_ack_i = 1'b0;
    store(32'h400, 32'd1, 1);
    store(32'h404, 32'd2, 1);
    check("ar_req", mem_req_o, 1);
    #2;
    reset_i = 1'b0;
    #1;
    check("ar_req0", mem_req_o, 0);
    check("ar_drained", drained_o, 1);
    check("ar_addr0", mem_addr_o, 0);
    sb_a.delete();
    sb_d.delete();
    tick(1);
    reset_i = 1'b1;
    mem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("ar_stale", mem_req_o, 0);
    end
    check("ar_drained2", drained_o, 1);

`ifdef STORE_DRAIN_WRITE_COMBINE_EN
    mem_ack_i = 1'b0;
    store(32'h30, 32'd1, 1);
    store(32'h40, 32'd2, 0);
    store(32'h40, 32'd3, 1);
    store(32'h50, 32'd4, 1);
    check("wc_not_full", full_o, 0);
    store(32'h60, 32'd5, 1);
    check("wc_full", full_o, 1);
    check("wc_ovf", overflow_o, 0);
    mem_ack_i = 1'b1;
    wait_drained(20);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
